sc_level_tick_sequencer: RTL and testbench

Parametrised level-driven load-tick sequencer for the Road Fighter datapath. Maps the current level count to one of three speed tiers, generates a one-cycle LOAD strobe every tier period to advance the playfield registers, and drives a one-hot mux select for the active tier. It adds start, pause, inter-tier blanking and an end-of-game stop. It sits between the level counter/comparator and the playfield register bank.

---
 rtl/sc_level_tick_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sc_level_tick_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_level_tick_sequencer.sv
// Level-driven load-tick sequencer: maps the level to a speed tier and emits a one-cycle
// LOAD strobe every tier period, with start, pause, inter-tier blanking and end-of-game stop.
module sc_level_tick_sequencer #(
  parameter int unsigned LEVELWIDTH   = 8,
  parameter int unsigned TIMERWIDTH   = 25,
  parameter int unsigned TH0          = 10,
  parameter int unsigned TH1          = 32,
  parameter int unsigned TH2          = 59,
  parameter int unsigned PERIOD0      = 17500000,
  parameter int unsigned PERIOD1      = 15000000,
  parameter int unsigned PERIOD2      = 12500000,
  parameter int unsigned BLANK_CYCLES = 25000000
) (
  input  logic                  SC_LEVELTICK_CLOCK_50,
  input  logic                  SC_LEVELTICK_RESET_InHigh,
  input  logic                  SC_LEVELTICK_START_InLow,
  input  logic                  SC_LEVELTICK_PAUSE_InHigh,
  input  logic [LEVELWIDTH-1:0] SC_LEVELTICK_LEVEL,
  output logic                  SC_LEVELTICK_LOAD_OUT,
  output logic [1:0]            SC_LEVELTICK_TIER_OUT,
  output logic [2:0]            SC_LEVELTICK_MUXSEL_OUT,
  output logic [TIMERWIDTH-1:0] SC_LEVELTICK_PERIOD_OUT,
  output logic                  SC_LEVELTICK_BLANK_OUT,
  output logic                  SC_LEVELTICK_DONE_OUT
);

  localparam logic [LEVELWIDTH-1:0] Th0Lvl = LEVELWIDTH'(TH0);
  localparam logic [LEVELWIDTH-1:0] Th1Lvl = LEVELWIDTH'(TH1);
  localparam logic [LEVELWIDTH-1:0] Th2Lvl = LEVELWIDTH'(TH2);

  localparam logic [TIMERWIDTH-1:0] Period0Val = TIMERWIDTH'(PERIOD0);
  localparam logic [TIMERWIDTH-1:0] Period1Val = TIMERWIDTH'(PERIOD1);
  localparam logic [TIMERWIDTH-1:0] Period2Val = TIMERWIDTH'(PERIOD2);
  localparam logic [TIMERWIDTH-1:0] BlankLast  = TIMERWIDTH'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StBlank,
    StPause,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              tier_q, tier_d;
  logic [TIMERWIDTH-1:0]   timer_q, timer_d;

  logic                    load_q, load_d;
  logic [1:0]              tier_out_q, tier_out_d;
  logic [2:0]              muxsel_q, muxsel_d;
  logic [TIMERWIDTH-1:0]   period_q, period_d;
  logic                    blank_q, blank_d;
  logic                    done_q, done_d;

  logic [1:0]              lvl_tier;
  logic                    lvl_over;
  logic                    tier_changed;
  logic [TIMERWIDTH-1:0]   cur_period;
  logic [TIMERWIDTH-1:0]   cur_last;
  logic                    active_d;

  function automatic logic [TIMERWIDTH-1:0] period_of(input logic [1:0] tier);
    logic [TIMERWIDTH-1:0] p;
    case (tier)
      2'd0:    p = Period0Val;
      2'd1:    p = Period1Val;
      default: p = Period2Val;
    endcase
    return p;
  endfunction

  // Level classification; unsigned compares at the level width.
  always_comb begin
    lvl_over = (SC_LEVELTICK_LEVEL > Th2Lvl);
    if (SC_LEVELTICK_LEVEL <= Th0Lvl) begin
      lvl_tier = 2'd0;
    end else if (SC_LEVELTICK_LEVEL <= Th1Lvl) begin
      lvl_tier = 2'd1;
    end else begin
      lvl_tier = 2'd2;
    end
  end

  assign tier_changed = (lvl_tier != tier_q);
  assign cur_period   = period_of(tier_q);
  assign cur_last     = cur_period - TIMERWIDTH'(1);

  always_comb begin
    state_d = state_q;
    tier_d  = tier_q;
    timer_d = timer_q;
    load_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!SC_LEVELTICK_START_InLow) begin
          timer_d = '0;
          if (lvl_over) begin
            state_d = StDone;
          end else begin
            tier_d  = lvl_tier;
            state_d = StRun;
          end
        end
      end

      // Priority: game over, tier change, pause, period expiry, count.
      StRun: begin
        if (lvl_over) begin
          state_d = StDone;
          timer_d = '0;
        end else if (tier_changed) begin
          tier_d  = lvl_tier;
          state_d = StBlank;
          timer_d = '0;
        end else if (SC_LEVELTICK_PAUSE_InHigh) begin
          state_d = StPause;
        end else if (timer_q == cur_last) begin
          load_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMERWIDTH'(1);
        end
      end

      // Pause is deliberately not looked at here.
      StBlank: begin
        if (lvl_over) begin
          state_d = StDone;
          timer_d = '0;
        end else if (tier_changed) begin
          tier_d  = lvl_tier;
          timer_d = '0;
        end else if (timer_q == BlankLast) begin
          state_d = StRun;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMERWIDTH'(1);
        end
      end

      // Timer and tier stay frozen; a tier change is picked up once back in RUN.
      StPause: begin
        if (lvl_over) begin
          state_d = StDone;
          timer_d = '0;
        end else if (!SC_LEVELTICK_PAUSE_InHigh) begin
          state_d = StRun;
        end
      end

      StDone: begin
        state_d = StDone;
      end

      default: begin
        state_d = StIdle;
        tier_d  = 2'd0;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are registered images of the next state so they line up with the state change.
  always_comb begin
    active_d   = (state_d == StRun) || (state_d == StBlank) || (state_d == StPause);
    tier_out_d = active_d ? tier_d : 2'd0;
    muxsel_d   = active_d ? (3'b001 << tier_d) : 3'b000;
    period_d   = active_d ? period_of(tier_d) : '0;
    blank_d    = (state_d == StBlank);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge SC_LEVELTICK_CLOCK_50) begin
    if (SC_LEVELTICK_RESET_InHigh) begin
      state_q    <= StIdle;
      tier_q     <= 2'd0;
      timer_q    <= '0;
      load_q     <= 1'b0;
      tier_out_q <= 2'd0;
      muxsel_q   <= 3'b000;
      period_q   <= '0;
      blank_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tier_q     <= tier_d;
      timer_q    <= timer_d;
      load_q     <= load_d;
      tier_out_q <= tier_out_d;
      muxsel_q   <= muxsel_d;
      period_q   <= period_d;
      blank_q    <= blank_d;
      done_q     <= done_d;
    end
  end

  assign SC_LEVELTICK_LOAD_OUT   = load_q;
  assign SC_LEVELTICK_TIER_OUT   = tier_out_q;
  assign SC_LEVELTICK_MUXSEL_OUT = muxsel_q;
  assign SC_LEVELTICK_PERIOD_OUT = period_q;
  assign SC_LEVELTICK_BLANK_OUT  = blank_q;
  assign SC_LEVELTICK_DONE_OUT   = done_q;

endmodule

// File: tb/tb_sc_level_tick_sequencer.sv
// Bench for sc_level_tick_sequencer: directed scenarios plus randomized traffic against a
// countdown-based behavioural model.
module tb_sc_level_tick_sequencer;

  localparam int unsigned LW  = 8;
  localparam int unsigned TW  = 25;
  localparam int unsigned TH0 = 10;
  localparam int unsigned TH1 = 32;
  localparam int unsigned TH2 = 59;
  localparam int unsigned P0  = 5;
  localparam int unsigned P1  = 4;
  localparam int unsigned P2  = 3;
  localparam int unsigned BC  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_n;
  logic          pause;
  logic [LW-1:0] level;
  logic          load;
  logic [1:0]    tier;
  logic [2:0]    muxsel;
  logic [TW-1:0] period;
  logic          blank;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: mode 0 idle, 1 run, 2 blank, 3 pause, 4 done.
  int m_mode = 0;
  int m_tier = 0;
  int m_left = 0;   // edges until the next LOAD while running
  int m_bl   = 0;   // blanking edges remaining
  bit m_load = 1'b0;

  always #5 clk = ~clk;

  sc_level_tick_sequencer #(
    .LEVELWIDTH  (LW),
    .TIMERWIDTH  (TW),
    .TH0         (TH0),
    .TH1         (TH1),
    .TH2         (TH2),
    .PERIOD0     (P0),
    .PERIOD1     (P1),
    .PERIOD2     (P2),
    .BLANK_CYCLES(BC)
  ) dut (
    .SC_LEVELTICK_CLOCK_50    (clk),
    .SC_LEVELTICK_RESET_InHigh(rst),
    .SC_LEVELTICK_START_InLow (start_n),
    .SC_LEVELTICK_PAUSE_InHigh(pause),
    .SC_LEVELTICK_LEVEL       (level),
    .SC_LEVELTICK_LOAD_OUT    (load),
    .SC_LEVELTICK_TIER_OUT    (tier),
    .SC_LEVELTICK_MUXSEL_OUT  (muxsel),
    .SC_LEVELTICK_PERIOD_OUT  (period),
    .SC_LEVELTICK_BLANK_OUT   (blank),
    .SC_LEVELTICK_DONE_OUT    (done)
  );

  function automatic int tier_of(input int l);
    if (l <= int'(TH0)) return 0;
    if (l <= int'(TH1)) return 1;
    return 2;
  endfunction

  function automatic int per(input int t);
    return (t == 0) ? int'(P0) : (t == 1) ? int'(P1) : int'(P2);
  endfunction

  task automatic model_step(input bit r, input bit s_n, input bit p, input int l);
    int  t;
    bit  ov;
    t  = tier_of(l);
    ov = (l > int'(TH2));
    m_load = 1'b0;
    if (r) begin
      m_mode = 0; m_tier = 0; m_left = 0; m_bl = 0;
      return;
    end
    case (m_mode)
      0: if (!s_n) begin
        if (ov) m_mode = 4;
        else begin m_tier = t; m_mode = 1; m_left = per(t); end
      end
      1: begin
        if (ov) m_mode = 4;
        else if (t != m_tier) begin m_tier = t; m_mode = 2; m_bl = int'(BC); end
        else if (p) m_mode = 3;
        else if (m_left == 1) begin m_load = 1'b1; m_left = per(m_tier); end
        else m_left = m_left - 1;
      end
      2: begin
        if (ov) m_mode = 4;
        else if (t != m_tier) begin m_tier = t; m_bl = int'(BC); end
        else if (m_bl == 1) begin m_mode = 1; m_left = per(m_tier); end
        else m_bl = m_bl - 1;
      end
      3: begin
        if (ov) m_mode = 4;
        else if (!p) m_mode = 1;
      end
      default: ;
    endcase
  endtask

  function automatic logic [32:0] m_exp();
    logic          act;
    logic [1:0]    t;
    logic [2:0]    mx;
    logic [TW-1:0] pr;
    act = (m_mode >= 1) && (m_mode <= 3);
    t   = act ? 2'(m_tier) : 2'd0;
    mx  = act ? 3'(1 << m_tier) : 3'd0;
    pr  = act ? TW'(per(m_tier)) : '0;
    return {m_load, t, mx, pr, (m_mode == 2), (m_mode == 4)};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {load, tier, muxsel, period, blank, done};
  endfunction

  task automatic tick();
    bit r, s, p;
    int l;
    r = rst; s = start_n; p = pause; l = int'(level);
    @(posedge clk);
    #1;
    model_step(r, s, p, l);
  endtask

  task automatic do_reset();
    rst = 1'b1; start_n = 1'b1; pause = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_n = 1'b0; pause = 1'b1; level = 8'd20;
    tick();
    rst = 1'b0; start_n = 1'b1; pause = 1'b0;
    n_cmp++;
    if (dut_vec() !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), 33'd0);
    end
  endtask

  task automatic test_tier0_loads();
    do_reset();
    level = 8'd3; start_n = 1'b0;
    tick();
    start_n = 1'b1;
    n_cmp++;
    if ({tier, muxsel, period} !== {2'd0, 3'b001, TW'(5)}) begin
      n_fail++;
      $display("FAIL start_tier0: got tier=%0d mux=%b per=%0d want 0 001 5", tier, muxsel, period);
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++;
      if (load !== ((i % 5 == 0) && (i <= 15))) begin
        n_fail++;
        $display("FAIL tier0_load edge %0d: got %b", i, load);
      end
    end
  endtask

  task automatic test_tier_change();
    do_reset();
    level = 8'd10; start_n = 1'b0;
    tick();
    start_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      if (i == 5) level = 8'd11;
      tick();
      n_cmp++;
      if ({load, blank, muxsel} !==
          {(i == 15 || i == 19 || i == 23), (i >= 5 && i <= 10), (i < 5) ? 3'b001 : 3'b010}) begin
        n_fail++;
        $display("FAIL tier_change edge %0d: got load=%b blank=%b mux=%b", i, load, blank, muxsel);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    level = 8'd40; start_n = 1'b0;
    tick();
    start_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) pause = 1'b1;
      if (i == 10) pause = 1'b0;
      tick();
      n_cmp++;
      if ({load, muxsel} !== {(i == 11 || i == 14), 3'b100}) begin
        n_fail++;
        $display("FAIL pause edge %0d: got load=%b mux=%b want load=%b mux=100",
                 i, load, muxsel, (i == 11 || i == 14));
      end
    end
  endtask

  task automatic test_game_over();
    do_reset();
    level = 8'd20; start_n = 1'b0;
    tick();
    start_n = 1'b1;
    repeat (3) tick();
    level = 8'd60;
    tick();
    n_cmp++;
    if ({done, muxsel, load} !== {1'b1, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL game_over: got done=%b mux=%b load=%b want 1 000 0", done, muxsel, load);
    end
    start_n = 1'b0; level = 8'd20;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== 33'd1) begin
        n_fail++;
        $display("FAIL done_hold cycle %0d: got %h want %h", i, dut_vec(), 33'd1);
      end
    end
    rst = 1'b1; start_n = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (dut_vec() !== 33'd0) begin
      n_fail++;
      $display("FAIL done_reset: got %h want %h", dut_vec(), 33'd0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    level = 8'd20; start_n = 1'b0;
    tick();
    start_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_cmp++;
      if (load !== (i == 4)) begin
        n_fail++;
        $display("FAIL mid_pre edge %0d: got load=%b want %b", i, load, (i == 4));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (dut_vec() !== 33'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want %h", dut_vec(), 33'd0);
    end
    start_n = 1'b0;
    tick();
    start_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if ({load, muxsel} !== {(i == 4), 3'b010}) begin
        n_fail++;
        $display("FAIL mid_restart edge %0d: got load=%b mux=%b", i, load, muxsel);
      end
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      level = 8'($urandom_range(0, 255));
      pause = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (dut_vec() !== 33'd0) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: got %h want %h", i, dut_vec(), 33'd0);
      end
    end
    pause = 1'b0; level = 8'd70; start_n = 1'b0;
    tick();
    start_n = 1'b1;
    n_cmp++;
    if (dut_vec() !== 33'd1) begin
      n_fail++;
      $display("FAIL idle_to_done: got %h want %h", dut_vec(), 33'd1);
    end
  endtask

  task automatic test_random();
    int bounds[6];
    bounds = '{10, 11, 32, 33, 59, 60};
    do_reset();
    level = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      start_n = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 1) == 0) level = 8'(bounds[$urandom_range(0, 5)]);
        else level = 8'($urandom_range(0, 62));
      end
      tick();
      n_cmp++;
      if (dut_vec() !== m_exp()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h want %h", i, dut_vec(), m_exp());
      end
    end
    rst = 1'b0; pause = 1'b0; start_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start_n = 1'b1; pause = 1'b0; level = '0;
    test_reset();
    test_tier0_loads();
    test_tier_change();
    test_pause();
    test_game_over();
    test_reset_mid();
    test_idle_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
